// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decoded-op handshake in, writeback port, and the
// registered operand bundle that feeds the ALU.
//
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer keeps valid and its payload
// stable until that transfer; ready may change freely and never waits on valid.
interface alu_issue_stage_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    in_rs;
   logic [AW-1:0]    in_rt;
   logic [AW-1:0]    in_rd;
   logic [2:0]       in_ctrl;
   logic             wb_en;
   logic [AW-1:0]    wb_addr;
   logic [WIDTH-1:0] wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       control;
   logic [AW-1:0]    dest;

   // decoder / writeback source / ALU consumer side
   modport master (
      output in_valid, in_rs, in_rt, in_rd, in_ctrl,
      output wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, A, B, control, dest
   );

   // issue stage side
   modport slave (
      input  in_valid, in_rs, in_rt, in_rd, in_ctrl,
      input  wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, A, B, control, dest
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand fetch and issue stage ahead of the 32-bit ALU: register file with
// same-cycle writeback bypass, pending-write scoreboard for RAW/WAW stalls,
// and a one-entry output register holding A/B/control/dest.
module alu_issue_stage #(
   parameter int WIDTH = 32,
   parameter int NREG  = 32,
   parameter int AW    = 5
) (
   input logic               clock,
   input logic               reset,
   alu_issue_stage_if.slave  bus
);

   logic [WIDTH-1:0] regs [NREG];
   logic [NREG-1:0]  pending;
   logic [NREG-1:0]  pending_nxt;

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             busy_rs;
   logic             busy_rt;
   logic             busy_rd;
   logic             hazard;
   logic             in_ready;
   logic             accept;

   logic             out_valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       control_q;
   logic [AW-1:0]    dest_q;

   // Operand A: r0 is hard zero, a same-cycle writeback to rs wins over the file
   always_comb begin
      opa = '0;
      if (bus.in_rs != '0) begin
         if (bus.wb_en && (bus.wb_addr == bus.in_rs)) opa = bus.wb_data;
         else                                          opa = regs[bus.in_rs];
      end
   end

   // Operand B: same read path as A, for rt
   always_comb begin
      opb = '0;
      if (bus.in_rt != '0) begin
         if (bus.wb_en && (bus.wb_addr == bus.in_rt)) opb = bus.wb_data;
         else                                          opb = regs[bus.in_rt];
      end
   end

   // Busy = pending write not being retired this very cycle; r0 is never busy
   always_comb begin
      busy_rs = (bus.in_rs != '0) && pending[bus.in_rs] &&
                !(bus.wb_en && (bus.wb_addr == bus.in_rs));
      busy_rt = (bus.in_rt != '0) && pending[bus.in_rt] &&
                !(bus.wb_en && (bus.wb_addr == bus.in_rt));
      busy_rd = (bus.in_rd != '0) && pending[bus.in_rd] &&
                !(bus.wb_en && (bus.wb_addr == bus.in_rd));
      hazard  = busy_rs | busy_rt | busy_rd;
      // ready ignores in_valid so the decoder can use it without a loop
      in_ready = (!out_valid_q || bus.out_ready) && !hazard;
      accept   = bus.in_valid && in_ready;
   end

   // Scoreboard update: writeback clears first, then a new issue sets (set wins)
   always_comb begin
      pending_nxt = pending;
      if (bus.wb_en && (bus.wb_addr != '0)) pending_nxt[bus.wb_addr] = 1'b0;
      if (accept && (bus.in_rd != '0))      pending_nxt[bus.in_rd]   = 1'b1;
   end

   // Scoreboard register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) pending <= '0;
      else        pending <= pending_nxt;
   end

   // Register file write port; r0 is never written so it stays zero
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (bus.wb_en && (bus.wb_addr != '0)) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Output register: load on accept, drop valid on drain, otherwise hold
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         control_q   <= '0;
         dest_q      <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         a_q         <= opa;
         b_q         <= opb;
         control_q   <= bus.in_ctrl;
         dest_q      <= bus.in_rd;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.control   = control_q;
   assign bus.dest      = dest_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// checked by a register/pending-set model and an ordered expected queue.
module tb_alu_issue_stage;

   logic clock;
   logic reset;

   alu_issue_stage_if #(.WIDTH(32), .AW(5)) bus ();

   alu_issue_stage #(.WIDTH(32), .NREG(32), .AW(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // expected ALU bundle {A, B, control, dest}
   logic [71:0] exp_q[$];

   // reference model: architectural register values and set of pending dests
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          last_acc;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a, input bit we,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (we && wa == a) return wd;
      return m_regs[a];
   endfunction

   function automatic bit m_busy(input logic [4:0] r, input bit we, input logic [4:0] wa);
      return (r != 5'd0) && m_pend[r] && !(we && wa == r);
   endfunction

   task automatic model_clear();
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // driver: apply one cycle of inputs, check ready, then advance the model
   task automatic cycle(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [2:0] c, input bit we,
                        input logic [4:0] wa, input logic [31:0] wd, input bit ordy);
      bit rdy;
      @(posedge clock);
      #1;
      bus.in_valid  = v;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_ctrl   = c;
      bus.wb_en     = we;
      bus.wb_addr   = wa;
      bus.wb_data   = wd;
      bus.out_ready = ordy;
      @(negedge clock);
      rdy = ((exp_q.size() == 0) || ordy) &&
            !(m_busy(rs, we, wa) || m_busy(rt, we, wa) || m_busy(rd, we, wa));
      check("in_ready", {71'd0, bus.in_ready}, {71'd0, rdy});
      #1;
      last_acc = v && rdy;
      if (last_acc) exp_q.push_back({m_read(rs, we, wa, wd), m_read(rt, we, wa, wd), c, rd});
      if (we && wa != 5'd0) begin
         m_regs[wa] = wd;
         m_pend[wa] = 1'b0;
      end
      if (last_acc && rd != 5'd0) m_pend[rd] = 1'b1;
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, ordy);
   endtask

   // monitor / scoreboard: every consumed op must match the oldest expectation
   always @(negedge clock) begin
      if (reset) begin
         check("out_valid", {71'd0, bus.out_valid}, {71'd0, exp_q.size() != 0});
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_op", {bus.A, bus.B, bus.control, bus.dest}, 72'hx);
            end else begin
               check("op_bundle", {bus.A, bus.B, bus.control, bus.dest}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [71:0] held;
      bit          cv;
      logic [4:0]  crs, crt, crd, cwa;
      logic [2:0]  cc;
      bit          cwe, cor;
      logic [31:0] cwd;

      bus.in_valid = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0; bus.in_ctrl = 0;
      bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.out_ready = 1;
      model_clear();

      // reset then idle
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_out_valid", {71'd0, bus.out_valid}, 72'd0);
      check("rst_A", {40'd0, bus.A}, 72'd0);
      check("rst_B", {40'd0, bus.B}, 72'd0);
      check("rst_in_ready", {71'd0, bus.in_ready}, 72'd1);
      reset = 1'b1;
      cycle(1'b1, 5'd0, 5'd0, 5'd0, 3'd1, 1'b0, 5'd0, 32'd0, 1'b1);
      idle(1'b1);

      // write then read
      cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd5, 32'h7, 1'b1);
      cycle(1'b1, 5'd5, 5'd0, 5'd6, 3'd2, 1'b0, 5'd0, 32'd0, 1'b1);
      idle(1'b1);
      check("rd_A7", {40'd0, bus.A}, 72'h7);
      check("rd_ctrl_dest", {64'd0, bus.control, bus.dest}, {64'd0, 3'd2, 5'd6});
      cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd6, 32'h1, 1'b1);

      // same-cycle bypass, and r0 ignores writes
      cycle(1'b1, 5'd9, 5'd9, 5'd0, 3'd3, 1'b1, 5'd9, 32'hDEADBEEF, 1'b1);
      idle(1'b1);
      check("bypass_AB", {8'd0, bus.A, bus.B}, {8'd0, 32'hDEADBEEF, 32'hDEADBEEF});
      cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
      cycle(1'b1, 5'd0, 5'd9, 5'd0, 3'd4, 1'b0, 5'd0, 32'd0, 1'b1);
      idle(1'b1);
      check("r0_zero", {40'd0, bus.A}, 72'd0);

      // RAW stall until the writeback to r3
      cycle(1'b1, 5'd0, 5'd0, 5'd3, 3'd5, 1'b0, 5'd0, 32'd0, 1'b1);
      repeat (3) cycle(1'b1, 5'd3, 5'd0, 5'd0, 3'd6, 1'b0, 5'd0, 32'd0, 1'b1);
      cycle(1'b1, 5'd3, 5'd0, 5'd0, 3'd6, 1'b1, 5'd3, 32'h10, 1'b1);
      idle(1'b1);
      check("raw_A", {40'd0, bus.A}, 72'h10);

      // backpressure: held output stays stable, then back-to-back issue
      cycle(1'b1, 5'd5, 5'd9, 5'd7, 3'd7, 1'b0, 5'd0, 32'd0, 1'b0);
      cycle(1'b1, 5'd9, 5'd5, 5'd8, 3'd1, 1'b0, 5'd0, 32'd0, 1'b0);
      held = {bus.A, bus.B, bus.control, bus.dest};
      repeat (3) begin
         cycle(1'b1, 5'd9, 5'd5, 5'd8, 3'd1, 1'b0, 5'd0, 32'd0, 1'b0);
         check("hold_stable", {bus.A, bus.B, bus.control, bus.dest}, held);
      end
      cycle(1'b1, 5'd9, 5'd5, 5'd8, 3'd1, 1'b0, 5'd0, 32'd0, 1'b1);
      check("b2b_accept", {71'd0, last_acc}, 72'd1);
      idle(1'b1);
      cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd7, 32'h77, 1'b1);
      cycle(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 5'd8, 32'h88, 1'b1);

      // reset mid-operation with out_valid=1 and r4 pending
      cycle(1'b1, 5'd0, 5'd0, 5'd4, 3'd2, 1'b0, 5'd0, 32'd0, 1'b0);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      bus.wb_en    = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", {71'd0, bus.out_valid}, 72'd0);
      check("mid_rst_AB", {8'd0, bus.A, bus.B}, 72'd0);
      check("mid_rst_in_ready", {71'd0, bus.in_ready}, 72'd1);
      model_clear();
      @(posedge clock);
      #1;
      reset = 1'b1;
      cycle(1'b1, 5'd4, 5'd5, 5'd0, 3'd3, 1'b0, 5'd0, 32'd0, 1'b1);
      check("post_rst_no_stall", {71'd0, last_acc}, 72'd1);
      idle(1'b1);

      // random traffic; a refused op is held unchanged until accepted
      cv = 0; crs = 0; crt = 0; crd = 0; cc = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!cv || last_acc) begin
            cv  = ($urandom_range(0, 3) != 0);
            crs = 5'($urandom_range(0, 7));
            crt = 5'($urandom_range(0, 7));
            crd = 5'($urandom_range(0, 7));
            cc  = 3'($urandom_range(0, 7));
         end
         cwe = ($urandom_range(0, 1) == 1);
         cwa = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 1; k < 8; k++) if (m_pend[k]) cwa = 5'(k);
         end
         cwd = $urandom;
         cor = ($urandom_range(0, 3) != 0);
         cycle(cv, crs, crt, crd, cc, cwe, cwa, cwd, cor);
      end

      repeat (3) idle(1'b1);
      check("queue_drained", 72'(exp_q.size()), 72'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Operand-fetch and issue stage directly upstream of the 32-bit ALU. It holds the 32-entry register file and accepts decoded ops (rs, rt, rd, 3-bit ALU control) through a valid/ready handshake. It registers A, B, control and dest into a one-entry output register that drives the ALU inputs. A pending-write scoreboard stalls RAW/WAW hazards, and a writeback port returns ALU results with same-cycle bypass.

Parameters:
WIDTH, 32, data width of registers and of the A/B operands
NREG, 32, number of architectural registers; register 0 reads as zero
AW, 5, register address width; must equal clog2(NREG)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  decoded op present
in_ready  output  1  stage accepts the op this cycle
in_rs  input  AW  source register for A
in_rt  input  AW  source register for B
in_rd  input  AW  destination register; 0 means no writeback
in_ctrl  input  3  ALU control code, passed through unchanged
wb_en  input  1  writeback strobe
wb_addr  input  AW  writeback register
wb_data  input  WIDTH  writeback value
out_valid  output  1  A/B/control/dest hold a valid op
out_ready  input  1  downstream consumed the op
A  output  WIDTH  operand A to the ALU
B  output  WIDTH  operand B to the ALU
control  output  3  ALU control
dest  output  AW  destination register carried alongside the op

Behaviour:
- Reset (reset=0, asynchronous): all registers=0, pending[]=0, out_valid=0, A=0, B=0, control=0, dest=0. Takes effect immediately, including mid-handshake; any in-flight op is dropped.
- Register file: writes on a clock edge when wb_en=1 and wb_addr!=0. Writes to r0 are ignored and r0 always reads 0.
- Operand read: combinational at accept. If wb_en=1 and wb_addr equals the source register (and is nonzero), wb_data is bypassed in the same cycle.
- Scoreboard: on accept with in_rd!=0, set pending[in_rd]. On wb_en with wb_addr!=0, clear pending[wb_addr]. If both target the same address in the same cycle, set wins.
- Hazard: a source or destination register r is "busy" if r!=0, pending[r]=1, and not (wb_en=1 and wb_addr==r). hazard = busy(rs) | busy(rt) | busy(rd).
- in_ready = (!out_valid | out_ready) & !hazard. It is combinational; in_ready does not depend on in_valid.
- Accept = in_valid & in_ready. On accept, the next clock edge loads A, B, control=in_ctrl, dest=in_rd and sets out_valid=1. Latency is 1 cycle from accept to out_valid.
- Output register:
  - if out_valid & out_ready and there is no accept, out_valid drops to 0 at the edge;
  - if out_valid & !out_ready, A/B/control/dest hold stable;
  - simultaneous drain and accept gives back-to-back issue, one op per cycle, with no bubble.
- Throughput is 1 op/cycle absent hazards. A stalled op must keep its inputs stable until accepted.
- Arithmetic: none. Data passes through unmodified at full WIDTH; no sign extension.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles -> out_valid=0, A=B=0, in_ready=1. Issue rs=0, rt=0 -> A=0, B=0 one cycle later.
- Write and read: wb r5=0x00000007. Next cycle issue rs=5, rt=0, ctrl=2, rd=6 -> out_valid=1, A=7, B=0, control=2, dest=6.
- Same-cycle bypass: wb r9=0xDEADBEEF in the same cycle as issue rs=9, rt=9 -> A=B=0xDEADBEEF. Writing r0=0xFFFFFFFF then reading rs=0 -> A=0.
- RAW stall: issue rd=3, then rs=3 -> in_ready=0 for every cycle until wb_en addr=3 data=0x10. In that cycle in_ready=1, and A=0x10 next cycle.
- Backpressure: out_ready=0 for 4 cycles with an op held -> A/B/control/dest stable and in_ready=0. Raise out_ready with a new op valid -> the next op issues back-to-back.
- Reset mid-operation: assert reset with out_valid=1 and pending[4]=1 -> out_valid=0 immediately, all registers 0. After release, an op with rs=4 issues without stall.
